debugger_sequencer: RTL
=======================

Name: debugger_sequencer

Overview:
- Parametrised APB-slave debug sequencer for the be8 CPU.
- Turns each APB read or write into a timed sequence of active-low CPU control strobes: register in/out, MAR load, RAM in/out.
- Host-side APB bridge on one side; CPU control-signal mux and shared data bus on the other.
- Extends the fixed-table debug microcode with a clocked FSM, configurable width and depth, RAM wait states, per-register access masks, and PSLVERR on illegal accesses.

Parameters:
- DATA_W, 8, CPU bus and APB data width.
- ADDR_W, 5, PADDR width.
- NUM_REGS, 8, CPU registers mapped at addresses 0..NUM_REGS-1.
- MEM_DEPTH, 16, RAM words mapped at NUM_REGS..NUM_REGS+MEM_DEPTH-1.
- MEM_WAIT, 0, extra cycles the RAM strobe is held (0..15).
- REG_RD_MASK, {NUM_REGS{1'b1}}, bit i=1: register i readable.
- REG_WR_MASK, {NUM_REGS{1'b1}}, bit i=1: register i writable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction (1 = write).
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- bus_in  in  DATA_W  CPU bus value, sampled on reads.
- bus_out  out  DATA_W  value the debugger drives onto the CPU bus.
- dbg_out_n  out  1  low = debugger drives the bus.
- reg_in_n  out  NUM_REGS  per-register load strobes, active low.
- reg_out_n  out  NUM_REGS  per-register output enables, active low.
- mar_in_n  out  1  MAR load, active low.
- ram_in_n  out  1  RAM write, active low.
- ram_out_n  out  1  RAM output enable, active low.

Behaviour:
- Reset (rst_n low at a clk edge) forces IDLE.
  - Outputs: all *_n = 1, pready = 0, pslverr = 0, prdata = 0, bus_out = 0.
  - Applies from any state. A transfer in flight is dropped with no further strobes.
- States: IDLE, REG, MAR, MEM, DONE.
- Strobes are Moore outputs decoded only from state and latched request. APB inputs never reach the strobes combinationally.
- IDLE:
  - On psel && !penable (setup phase), latch paddr, pwrite, pwdata.
  - Classify the address:
    - paddr < NUM_REGS, mask bit set for that direction -> REG.
    - paddr in RAM window -> MAR.
    - Otherwise (out-of-range or masked) -> DONE with an error flag.
- REG, 1 cycle:
  - Read: reg_out_n[idx] = 0; prdata <= bus_in at the exiting edge.
  - Write: dbg_out_n = 0, bus_out = pwdata, reg_in_n[idx] = 0.
  - Next state DONE.
- MAR, 1 cycle:
  - dbg_out_n = 0, bus_out = zero-extended (paddr - NUM_REGS), mar_in_n = 0.
  - Next state MEM; wait counter loaded with MEM_WAIT.
- MEM, MEM_WAIT+1 cycles:
  - Read: ram_out_n = 0 for every MEM cycle; prdata <= bus_in on the last cycle only.
  - Write: dbg_out_n = 0 and bus_out = pwdata for every MEM cycle; ram_in_n = 0 on the last cycle only (single write edge).
  - Counter decrements each cycle and wraps nowhere. Exit to DONE when it reaches 0.
- DONE, 1 cycle:
  - pready = 1; pslverr = error flag.
  - No strobes asserted; prdata holds the captured value.
  - Next state IDLE.
- Latency, setup edge to pready:
  - Register: 2 cycles.
  - Memory: 3+MEM_WAIT cycles.
  - Error: 1 cycle.
  - APB wait states are inserted by holding pready low.
- Error reads return prdata = 0; error writes change nothing.
- psel low in REG, MAR or MEM: abort to IDLE at the next edge and deassert strobes. A partial MAR load is allowed.
- Setup phase with psel && penable already high in IDLE is ignored (no new start).
- prdata keeps its value until the next read completes; writes do not clear it.

Optional Feature:
- Macro: DEBUGGER_STATUS_REG_EN.
- Defined:
  - Read-only status register at address NUM_REGS+MEM_DEPTH.
  - Returns {err_cnt[DATA_W/2-1:0], xfer_cnt[DATA_W/2-1:0]}.
  - xfer_cnt counts every DONE; err_cnt counts erroring DONEs. Both saturate at all-ones and clear on reset.
  - Status read latency: 1 cycle (IDLE -> DONE), no strobes.
  - Writes to the status address: pslverr = 1.
- Undefined: that address is out-of-range and gives pslverr = 1; no counters are implemented.

Decomposition:
- Package debugger_pkg:
  - State enum (IDLE, REG, MAR, MEM, DONE).
  - Access-class enum (ACC_REG, ACC_MEM, ACC_STAT, ACC_ERR).
  - WAIT_CNT_W = 4 constant.
- Sub-module debugger_addr_decode, combinational:
  - Inputs: paddr, pwrite, masks.
  - Outputs: access class, register index, RAM offset.
  - Sequencer instantiates one.

Test Plan:
- Reset: hold rst_n low 2 cycles mid-MEM -> next cycle all *_n = 1, pready = 0, prdata = 0, state IDLE.
- Register write: write paddr = 3, pwdata = 0xA5 -> one cycle with reg_in_n = 8'b11110111, dbg_out_n = 0, bus_out = 0xA5; pready high 2 cycles after setup; pslverr = 0.
- Register read: read paddr = 1, bus_in = 0x3C -> reg_out_n[1] low one cycle; prdata = 0x3C with pready.
- RAM write, MEM_WAIT = 2: write paddr = 0x0D, pwdata = 0x7E
  - mar_in_n low 1 cycle with bus_out = 0x05.
  - Then 3 MEM cycles, ram_in_n low only on the third.
  - pready 5 cycles after setup.
- Errors, REG_WR_MASK bit 6 = 0:
  - Write paddr = 6 -> no strobes, pready + pslverr after 1 cycle.
  - Read paddr = 0x1F -> prdata = 0, pslverr = 1.
- Abort: drop psel during MEM of a RAM read -> strobes deasserted next cycle, state IDLE; a following register read completes normally.

Source files
------------

// File: rtl/debugger_pkg.sv
// Shared types and constants for the be8 debug sequencer.
package debugger_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    REG,
    MAR,
    MEM,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ACC_REG,
    ACC_MEM,
    ACC_STAT,
    ACC_ERR
  } acc_e;

  // Width of a register index; a single register still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debugger_addr_decode.sv
// Classifies an APB address as a CPU register, RAM word, status word or error.
// Optional status word enabled by DEBUGGER_STATUS_REG_EN.
module debugger_addr_decode
  import debugger_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 8,
  parameter int MEM_DEPTH = 16,
  parameter int IDX_W     = idx_width(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                pwrite,
  input  logic [NUM_REGS-1:0] rd_mask,
  input  logic [NUM_REGS-1:0] wr_mask,
  output acc_e                acc,
  output logic [IDX_W-1:0]    reg_idx,
  output logic [ADDR_W-1:0]   ram_off
);

  localparam logic [31:0] REG_END = 32'(NUM_REGS);
  localparam logic [31:0] MEM_END = 32'(NUM_REGS + MEM_DEPTH);

  logic [31:0] addr_ext;

  // Compare in a wide domain so odd parameter choices cannot wrap the window checks.
  always_comb begin
    addr_ext = 32'(paddr);
    reg_idx  = IDX_W'(paddr);
    ram_off  = paddr - ADDR_W'(NUM_REGS);
    acc      = ACC_ERR;
    if (addr_ext < REG_END) begin
      if (pwrite ? wr_mask[reg_idx] : rd_mask[reg_idx]) begin
        acc = ACC_REG;
      end
    end else if (addr_ext < MEM_END) begin
      acc = ACC_MEM;
    end
`ifdef DEBUGGER_STATUS_REG_EN
    else if ((addr_ext == MEM_END) && !pwrite) begin
      acc = ACC_STAT;
    end
`endif
  end

endmodule

// File: rtl/debugger_sequencer.sv
// APB-slave debug sequencer: turns APB reads/writes into timed active-low
// strobes for the be8 CPU registers, MAR and RAM.
// Optional read-only status counters enabled by DEBUGGER_STATUS_REG_EN.
module debugger_sequencer
  import debugger_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 5,
  parameter int                NUM_REGS    = 8,
  parameter int                MEM_DEPTH   = 16,
  parameter int                MEM_WAIT    = 0,
  parameter logic [NUM_REGS-1:0] REG_RD_MASK = {NUM_REGS{1'b1}},
  parameter logic [NUM_REGS-1:0] REG_WR_MASK = {NUM_REGS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic                dbg_out_n,
  output logic [NUM_REGS-1:0] reg_in_n,
  output logic [NUM_REGS-1:0] reg_out_n,
  output logic                mar_in_n,
  output logic                ram_in_n,
  output logic                ram_out_n
);

  localparam int IDX_W = idx_width(NUM_REGS);

  acc_e                dec_acc;
  logic [IDX_W-1:0]    dec_idx;
  logic [ADDR_W-1:0]   dec_off;
  logic [DATA_W-1:0]   status_word;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic                dbg_out_n_q, dbg_out_n_d;
  logic [NUM_REGS-1:0] reg_in_n_q, reg_in_n_d;
  logic [NUM_REGS-1:0] reg_out_n_q, reg_out_n_d;
  logic                mar_in_n_q, mar_in_n_d;
  logic                ram_in_n_q, ram_in_n_d;
  logic                ram_out_n_q, ram_out_n_d;

  debugger_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .rd_mask(REG_RD_MASK),
    .wr_mask(REG_WR_MASK),
    .acc    (dec_acc),
    .reg_idx(dec_idx),
    .ram_off(dec_off)
  );

`ifdef DEBUGGER_STATUS_REG_EN
  localparam int HALF_W = DATA_W / 2;

  logic [HALF_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [HALF_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating counts of completed and erroring transfers, bumped on DONE entry.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_d == DONE) begin
      if (xfer_cnt_q != '1) xfer_cnt_d = xfer_cnt_q + 1'b1;
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign status_word = DATA_W'({err_cnt_q, xfer_cnt_q});
`else
  assign status_word = '0;
`endif

  // Next state, latched request and strobes; strobes decode from the next state so they leave as flops.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          wr_d    = pwrite;
          idx_d   = dec_idx;
          off_d   = dec_off;
          wdata_d = pwdata;
          err_d   = 1'b0;
          unique case (dec_acc)
            ACC_REG:  state_d = REG;
            ACC_MEM:  state_d = MAR;
            ACC_STAT: begin
              state_d  = DONE;
              prdata_d = status_word;
            end
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
              if (!pwrite) prdata_d = '0;
            end
          endcase
        end
      end
      REG: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (!wr_q) prdata_d = bus_in;
        end
      end
      MAR: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          state_d = MEM;
          cnt_d   = WAIT_CNT_W'(MEM_WAIT);
        end
      end
      MEM: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) prdata_d = bus_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    bus_out_d   = '0;
    dbg_out_n_d = 1'b1;
    reg_in_n_d  = '1;
    reg_out_n_d = '1;
    mar_in_n_d  = 1'b1;
    ram_in_n_d  = 1'b1;
    ram_out_n_d = 1'b1;

    unique case (state_d)
      REG: begin
        if (wr_d) begin
          dbg_out_n_d       = 1'b0;
          bus_out_d         = wdata_d;
          reg_in_n_d[idx_d] = 1'b0;
        end else begin
          reg_out_n_d[idx_d] = 1'b0;
        end
      end
      MAR: begin
        dbg_out_n_d = 1'b0;
        bus_out_d   = DATA_W'(off_d);
        mar_in_n_d  = 1'b0;
      end
      MEM: begin
        if (wr_d) begin
          dbg_out_n_d = 1'b0;
          bus_out_d   = wdata_d;
          if (cnt_d == '0) ram_in_n_d = 1'b0;
        end else begin
          ram_out_n_d = 1'b0;
        end
      end
      DONE: begin
        pready_d  = 1'b1;
        pslverr_d = err_d;
      end
      default: ;
    endcase
  end

  // Single state register for the sequencer; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      bus_out_q   <= '0;
      dbg_out_n_q <= 1'b1;
      reg_in_n_q  <= '1;
      reg_out_n_q <= '1;
      mar_in_n_q  <= 1'b1;
      ram_in_n_q  <= 1'b1;
      ram_out_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      bus_out_q   <= bus_out_d;
      dbg_out_n_q <= dbg_out_n_d;
      reg_in_n_q  <= reg_in_n_d;
      reg_out_n_q <= reg_out_n_d;
      mar_in_n_q  <= mar_in_n_d;
      ram_in_n_q  <= ram_in_n_d;
      ram_out_n_q <= ram_out_n_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign bus_out   = bus_out_q;
  assign dbg_out_n = dbg_out_n_q;
  assign reg_in_n  = reg_in_n_q;
  assign reg_out_n = reg_out_n_q;
  assign mar_in_n  = mar_in_n_q;
  assign ram_in_n  = ram_in_n_q;
  assign ram_out_n = ram_out_n_q;

endmodule
